bytestream_ft245_fifo: RTL

- Next-generation FT232/FT245-style asynchronous FIFO bridge. It adds parametrised internal RX and TX buffering, a valid/consume handshake with backpressure on the RX side, and burst-limited round-robin arbitration between read and write.
- Sits between the FTDI pins and the bytestream consumers/producers (debug/loader links). It decouples bursty host traffic from slow or stalled fabric consumers.

---
 rtl/bytestream_ft245_fifo.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bytestream_ft245_fifo.sv
// FT232/FT245-style asynchronous FIFO bridge.
// Buffers host->fabric bytes in an RX FIFO and fabric->host bytes in a TX
// FIFO, and time-shares the FTDI bus between reads and writes with a
// burst-limited round-robin arbiter.
//
// Handshake rules for both byte streams: a byte moves on a rising clk edge
// exactly when its valid and consume signals are both high on that edge.
// bs_data_in_consume is combinational from bs_data_in_valid and TX space.
// bs_data_out_valid depends only on RX occupancy, and consume while empty
// is ignored.
module bytestream_ft245_fifo #(
    parameter int STROBE_WIDTH = 2,
    parameter int SETUP        = 0,
    parameter int HOLD         = 0,
    parameter int DVALID       = 1,
    parameter int IDLE_WAIT    = 6,
    parameter int RX_LOG2      = 4,
    parameter int TX_LOG2      = 4,
    parameter int BURST        = 4
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [7:0]         ft_data,
    input  logic               ft_nRXF,
    output logic               ft_nRD,
    input  logic               ft_nTXE,
    output logic               ft_nWR,
    input  logic [7:0]         bs_data_in,
    input  logic               bs_data_in_valid,
    output logic               bs_data_in_consume,
    output logic [7:0]         bs_data_out,
    output logic               bs_data_out_valid,
    input  logic               bs_data_out_consume,
    output logic [RX_LOG2:0]   rx_level,
    output logic [TX_LOG2:0]   tx_level,
    output logic [2:0]         dbg_state
);

    localparam int RX_DEPTH = 1 << RX_LOG2;
    localparam int TX_DEPTH = 1 << TX_LOG2;
    localparam int WR_LOW   = (HOLD > STROBE_WIDTH) ? HOLD : STROBE_WIDTH;

    localparam logic [RX_LOG2:0]   RX_FULL    = (RX_LOG2+1)'(RX_DEPTH);
    localparam logic [TX_LOG2:0]   TX_FULL    = (TX_LOG2+1)'(TX_DEPTH);
    localparam logic [RX_LOG2:0]   RX_LVL_ONE = (RX_LOG2+1)'(1);
    localparam logic [TX_LOG2:0]   TX_LVL_ONE = (TX_LOG2+1)'(1);
    localparam logic [RX_LOG2-1:0] RX_PTR_ONE = RX_LOG2'(1);
    localparam logic [TX_LOG2-1:0] TX_PTR_ONE = TX_LOG2'(1);

    localparam logic [7:0] T_DVALID    = 8'(DVALID);
    localparam logic [7:0] T_RDPROD    = 8'(STROBE_WIDTH - DVALID);
    localparam logic [7:0] T_SETUP     = 8'(SETUP);
    localparam logic [7:0] T_WRLOW     = 8'(WR_LOW);
    localparam logic [7:0] T_IDLE_WAIT = 8'(IDLE_WAIT);
    localparam logic [7:0] BURST_L     = 8'(BURST);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RDWAIT    = 3'd1,
        S_RDPROD    = 3'd2,
        S_WRSETUP   = 3'd3,
        S_WRHOLD    = 3'd4,
        S_IDLE_WAIT = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         timer;
    logic               drive;
    logic               dir_rd;      // 0 = WRITE, 1 = READ
    logic [7:0]         run;
    logic [7:0]         run_inc;

    logic               rxf_meta, rxf_s;
    logic               txe_meta, txe_s;

    logic [7:0]         rx_mem [RX_DEPTH];
    logic [RX_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic               rx_push, rx_pop;

    logic [7:0]         tx_mem [TX_DEPTH];
    logic [TX_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
    logic               tx_push, tx_pop;
    logic [7:0]         wr_hold;

    logic               rd_ok, wr_ok;
    logic               pick_rd, pick_wr;

    assign dbg_state = state;
    assign ft_data   = drive ? wr_hold : 8'hzz;

    // Two-flop synchronisers for the asynchronous FTDI status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            rxf_meta <= ft_nRXF;
            rxf_s    <= rxf_meta;
            txe_meta <= ft_nTXE;
            txe_s    <= txe_meta;
        end
    end

    // RX side: capture point pushes, consumer pops
    assign rx_push           = (state == S_RDWAIT) && (timer == '0);
    assign rx_pop            = bs_data_out_consume && (rx_level != '0);
    assign bs_data_out       = rx_mem[rx_rd_ptr];
    assign bs_data_out_valid = (rx_level != '0);

    // TX side: producer pushes, arbiter pops when it starts a write
    assign bs_data_in_consume = !reset && bs_data_in_valid && (tx_level < TX_FULL);
    assign tx_push            = bs_data_in_consume;
    assign tx_pop             = pick_wr;

    // Eligibility and burst-limited round-robin pick, meaningful only in IDLE
    assign rd_ok   = !rxf_s && (rx_level < RX_FULL);
    assign wr_ok   = !txe_s && (tx_level != '0);
    assign run_inc = (run < BURST_L) ? run + 8'd1 : BURST_L;

    // Choose the next transfer direction from the two eligibility flags
    always_comb begin
        pick_rd = 1'b0;
        pick_wr = 1'b0;
        if (state == S_IDLE) begin
            if (rd_ok && wr_ok) begin
                if (run < BURST_L) begin
                    pick_rd = dir_rd;
                    pick_wr = !dir_rd;
                end else begin
                    pick_rd = !dir_rd;
                    pick_wr = dir_rd;
                end
            end else begin
                pick_rd = rd_ok;
                pick_wr = wr_ok;
            end
        end
    end

    // RX storage array; pointers alone decide what is valid
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= ft_data;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + RX_LVL_ONE;
                2'b01:   rx_level <= rx_level - RX_LVL_ONE;
                default: rx_level <= rx_level;
            endcase
        end
    end

    // TX storage array and the write holding register loaded at pop time
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bs_data_in;
        end
        if (tx_pop) begin
            wr_hold <= tx_mem[tx_rd_ptr];
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + TX_LVL_ONE;
                2'b01:   tx_level <= tx_level - TX_LVL_ONE;
                default: tx_level <= tx_level;
            endcase
        end
    end

    // Bus sequencer: strobes, bus drive and timer, all registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            timer  <= '0;
            ft_nRD <= 1'b1;
            ft_nWR <= 1'b1;
            drive  <= 1'b0;
            dir_rd <= 1'b0;
            run    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_rd || pick_wr) begin
                        if (pick_rd == dir_rd) begin
                            run <= run_inc;
                        end else begin
                            dir_rd <= pick_rd;
                            run    <= 8'd1;
                        end
                    end
                    if (pick_rd) begin
                        state  <= S_RDWAIT;
                        ft_nRD <= 1'b0;
                        timer  <= T_DVALID;
                    end else if (pick_wr) begin
                        state <= S_WRSETUP;
                        drive <= 1'b1;
                        timer <= T_SETUP;
                    end
                end
                S_RDWAIT: begin
                    if (timer == '0) begin
                        state <= S_RDPROD;
                        timer <= T_RDPROD;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                S_RDPROD: begin
                    if (timer == '0) begin
                        state  <= S_IDLE_WAIT;
                        ft_nRD <= 1'b1;
                        timer  <= T_IDLE_WAIT;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                S_WRSETUP: begin
                    if (timer == '0) begin
                        state  <= S_WRHOLD;
                        ft_nWR <= 1'b0;
                        timer  <= T_WRLOW;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                S_WRHOLD: begin
                    if (timer == '0) begin
                        state  <= S_IDLE_WAIT;
                        ft_nWR <= 1'b1;
                        drive  <= 1'b0;
                        timer  <= T_IDLE_WAIT;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                S_IDLE_WAIT: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
